// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: registered ALU control decode with a MULT/DIV busy/done sequencer.
// Define ALU_CTRL_PERF_EN to add stall-cycle and illegal-capture counters.
module alu_ctrl_mc #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [5:0]        funct_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              valid_o,
  output logic              illegal_o,
  output logic              mc_start_o,
  output logic              mc_busy_o,
  output logic              mc_done_o,
`ifdef ALU_CTRL_PERF_EN
  output logic [31:0]       perf_stall_o,
  output logic [15:0]       perf_illegal_o,
`endif
  output logic              stall_req_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid, r_illegal, r_start;
  logic [3:0]        w_op;
  logic              w_illegal, w_mc, w_div, w_hold, w_cap, w_start;
  logic [CTRL_W-1:0] w_ctrl;
  always_comb begin
    w_op      = 4'b0010;
    w_illegal = 1'b0;
    case (ALUOp_i)
      2'b00: w_op = 4'b0010;
      2'b01: w_op = 4'b0110;
      2'b11: w_op = 4'b0001;
      default:
        case (funct_i)
          6'b100000: w_op = 4'b0010;
          6'b100010: w_op = 4'b0110;
          6'b100100: w_op = 4'b0000;
          6'b100101: w_op = 4'b0001;
          6'b100111: w_op = 4'b1100;
          6'b101010: w_op = 4'b0111;
          6'b011000: w_op = 4'b1000;
          6'b011010: w_op = 4'b1001;
          default: begin
            w_op      = 4'b1111;
            w_illegal = 1'b1;
          end
        endcase
    endcase
  end
  assign w_ctrl  = w_illegal ? '1 : CTRL_W'(w_op);
  assign w_div   = (ALUOp_i == 2'b10) && (funct_i == 6'b011010);
  assign w_mc    = w_div || ((ALUOp_i == 2'b10) && (funct_i == 6'b011000));
  // A running multi-cycle op freezes the output register just like an external stall.
  assign w_hold  = stall_i || (r_state == S_RUN);
  assign w_cap   = !flush_i && !w_hold;
  assign w_start = w_cap && valid_i && w_mc;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_start   <= 1'b0;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
    end else begin
      if (flush_i) begin
        r_ctrl    <= '0;
        r_valid   <= 1'b0;
        r_illegal <= 1'b0;
      end else if (!w_hold) begin
        r_ctrl    <= w_ctrl;
        r_valid   <= valid_i;
        r_illegal <= valid_i && w_illegal;
      end
      r_start <= w_start;
      if (w_start) begin
        r_state <= S_RUN;
        r_cnt   <= w_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
      end else if (r_state == S_RUN) begin
        r_cnt   <= (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
        r_state <= (r_cnt != '0) ? S_RUN : S_DONE;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end
`ifdef ALU_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_illegal;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_stall   <= '0;
      r_perf_illegal <= '0;
    end else begin
      if (mc_busy_o && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
      if (w_cap && valid_i && w_illegal && r_perf_illegal != '1) r_perf_illegal <= r_perf_illegal + 1'b1;
    end
  end
  assign perf_stall_o   = r_perf_stall;
  assign perf_illegal_o = r_perf_illegal;
`endif
  assign ALUCtrl_o   = r_ctrl;
  assign valid_o     = r_valid;
  assign illegal_o   = r_illegal;
  assign mc_start_o  = r_start;
  assign mc_busy_o   = (r_state == S_RUN);
  assign mc_done_o   = (r_state == S_DONE);
  assign stall_req_o = mc_busy_o;
endmodule

// File: tb/tb_alu_ctrl_mc.sv
// tb_alu_ctrl_mc: directed vectors for alu_ctrl_mc with hand-computed expectations.
module tb_alu_ctrl_mc;
  logic       clk_i = 1'b0;
  logic       rst_i, valid_i, stall_i, flush_i;
  logic [5:0] funct_i;
  logic [1:0] ALUOp_i;
  logic [3:0] ALUCtrl_o;
  logic       valid_o, illegal_o, mc_start_o, mc_busy_o, mc_done_o, stall_req_o;
  int n_run = 0;
  int n_fail = 0;
  alu_ctrl_mc dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct_i(funct_i),
    .ALUOp_i(ALUOp_i), .stall_i(stall_i), .flush_i(flush_i),
    .ALUCtrl_o(ALUCtrl_o), .valid_o(valid_o), .illegal_o(illegal_o),
    .mc_start_o(mc_start_o), .mc_busy_o(mc_busy_o), .mc_done_o(mc_done_o),
    .stall_req_o(stall_req_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
    valid_i = v;
    ALUOp_i = op;
    funct_i = f;
  endtask
  logic [5:0] fv [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [3:0] cv [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
  int dn;
  initial begin
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 2'b00, 6'b0);
    tick; tick;
    chk("rst_ctrl", ALUCtrl_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", mc_busy_o, 0);
    chk("rst_done", mc_done_o, 0);
    rst_i = 1'b0;
    drive(1'b1, 2'b10, 6'b100010);
    tick;
    chk("sub_ctrl", ALUCtrl_o, 4'b0110);
    chk("sub_valid", valid_o, 1);
    chk("sub_ill", illegal_o, 0);
    chk("sub_busy", mc_busy_o, 0);
    drive(1'b1, 2'b00, 6'b0); tick; chk("op00", ALUCtrl_o, 4'b0010);
    drive(1'b1, 2'b01, 6'b0); tick; chk("op01", ALUCtrl_o, 4'b0110);
    drive(1'b1, 2'b11, 6'b0); tick; chk("op11", ALUCtrl_o, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'b10, fv[i]);
      tick;
      chk("rtype", ALUCtrl_o, cv[i]);
    end
    // mult, then a back-to-back mult during the done cycle
    drive(1'b1, 2'b10, 6'b011000);
    tick;
    chk("mul_start", mc_start_o, 1);
    chk("mul_ctrl", ALUCtrl_o, 4'b1000);
    drive(1'b1, 2'b10, 6'b100000);
    for (int i = 1; i < 4; i++) begin
      chk("mul_busy", mc_busy_o, 1);
      chk("mul_sreq", stall_req_o, 1);
      tick;
      chk("mul_nostart", mc_start_o, 0);
      chk("mul_held", ALUCtrl_o, 4'b1000);
    end
    chk("mul_busy4", mc_busy_o, 1);
    tick;
    chk("mul_done", mc_done_o, 1);
    chk("mul_idle", mc_busy_o, 0);
    chk("mul_sreq0", stall_req_o, 0);
    drive(1'b1, 2'b10, 6'b011000);
    tick;
    chk("b2b_start", mc_start_o, 1);
    chk("b2b_busy", mc_busy_o, 1);
    chk("b2b_nodone", mc_done_o, 0);
    drive(1'b1, 2'b10, 6'b100000);
    tick; tick; tick;
    chk("b2b_busy4", mc_busy_o, 1);
    tick;
    chk("b2b_done", mc_done_o, 1);
    tick;
    chk("b2b_after", mc_done_o, 0);
    chk("b2b_add", ALUCtrl_o, 4'b0010);
    // stall and flush
    drive(1'b1, 2'b01, 6'b0); tick; chk("pre_sf", ALUCtrl_o, 4'b0110);
    stall_i = 1'b1; flush_i = 1'b1;
    drive(1'b1, 2'b00, 6'b0);
    tick;
    chk("flush_valid", valid_o, 0);
    chk("flush_ctrl", ALUCtrl_o, 0);
    stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b1, 2'b01, 6'b0); tick;
    stall_i = 1'b1;
    drive(1'b1, 2'b00, 6'b0);
    tick;
    chk("stall_ctrl", ALUCtrl_o, 4'b0110);
    chk("stall_valid", valid_o, 1);
    stall_i = 1'b0;
    drive(1'b1, 2'b10, 6'b111111);
    tick;
    chk("ill_ctrl", ALUCtrl_o, 4'b1111);
    chk("ill_flag", illegal_o, 1);
    chk("ill_valid", valid_o, 1);
    chk("ill_nostart", mc_start_o, 0);
    chk("ill_nobusy", mc_busy_o, 0);
    drive(1'b0, 2'b00, 6'b0);
    tick;
    chk("inv_valid", valid_o, 0);
    chk("inv_ctrl", ALUCtrl_o, 4'b0010);
    chk("inv_ill", illegal_o, 0);
    // div interrupted by reset in busy cycle 10
    drive(1'b1, 2'b10, 6'b011010);
    tick;
    chk("div_start", mc_start_o, 1);
    chk("div_ctrl", ALUCtrl_o, 4'b1001);
    drive(1'b0, 2'b00, 6'b0);
    for (int i = 0; i < 9; i++) tick;
    chk("div_busy10", mc_busy_o, 1);
    rst_i = 1'b1;
    tick;
    chk("drst_ctrl", ALUCtrl_o, 0);
    chk("drst_valid", valid_o, 0);
    chk("drst_busy", mc_busy_o, 0);
    chk("drst_start", mc_start_o, 0);
    rst_i = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      dn += int'(mc_done_o);
    end
    chk("drst_nodone", dn, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
